// File: rtl/ttt_judge_if.sv
// Move/result bus between the game controller and the judge.
// Carries the move handshake, the error/result pulses and the flattened board.
// The master modport is the controller side; slave is the judge side.
interface ttt_judge_if #(
  parameter int N = 3
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic            move_valid;
  logic            move_ready;
  logic [IW-1:0]   move_row;
  logic [IW-1:0]   move_col;
  logic [1:0]      move_player;
  logic            move_ack;
  logic            move_err;
  logic [1:0]      err_code;
  logic [1:0]      status;
  logic            result_valid;
  logic [2*N*N-1:0] board_flat;

  modport master (
    output move_valid, move_row, move_col, move_player,
    input  move_ready, move_ack, move_err, err_code, status, result_valid, board_flat
  );

  modport slave (
    input  move_valid, move_row, move_col, move_player,
    output move_ready, move_ack, move_err, err_code, status, result_valid, board_flat
  );
endinterface

// File: rtl/ttt_judge.sv
// Sequential N x N, K-in-a-row game judge: validates moves, owns the board, scans lines through the last move.
// Latency: transfer edge -> move_ack next cycle; result_valid after (probe cycles + 2) edges.
// Backpressure: move_ready only in IDLE; held low while scanning, reporting and after game over.
module ttt_judge #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  ttt_judge_if.slave bus
);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = $clog2(N * N + 1);
  localparam int RW    = $clog2(K + 1);
  localparam int OW    = (K > 2) ? $clog2(K) : 1;
  localparam int PW    = IW + 2;
  localparam int CELLS = N * N;
  localparam logic signed [PW-1:0] NS = PW'(N);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;
  localparam logic [1:0] OVER   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic [1:0]         turn_q, turn_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      run_q, run_d;
  logic [OW-1:0]      off_q, off_d;
  logic [1:0]         dir_q, dir_d;
  logic               side_q, side_d;
  logic               win_q, win_d;
  logic [IW-1:0]      lr_q, lr_d, lc_q, lc_d;
  logic               ack_q, ack_d, err_q, err_d, rv_q, rv_d;
  logic [1:0]         code_q, code_d, status_q, status_d;

  // probe geometry
  logic               rm, rneg, cm, cneg;
  logic signed [PW-1:0] lrs, lcs, offs, pr, pc;
  logic               on_board, probe_match;
  logic [1:0]         probe_cell;
  int                 pidx;

  // move decode
  logic               in_range, occupied, side_end;
  int                 midx;

  assign lrs  = signed'({2'b00, lr_q});
  assign lcs  = signed'({2'b00, lc_q});
  assign offs = signed'({{(PW-OW){1'b0}}, off_q});

  // Current probe coordinate from last move, direction, side and offset, plus the cell it hits.
  always_comb begin
    rm   = 1'b0;
    rneg = 1'b0;
    cm   = 1'b0;
    cneg = 1'b0;
    case (dir_q)
      2'd0:    cm = 1'b1;
      2'd1:    rm = 1'b1;
      2'd2:    begin rm = 1'b1; cm = 1'b1; end
      default: begin rm = 1'b1; cm = 1'b1; cneg = 1'b1; end
    endcase
    rneg = rneg ^ side_q;
    cneg = cneg ^ side_q;
    pr = rm ? (rneg ? lrs - offs : lrs + offs) : lrs;
    pc = cm ? (cneg ? lcs - offs : lcs + offs) : lcs;
    on_board = !pr[PW-1] && (pr < NS) && !pc[PW-1] && (pc < NS);
    pidx = int'(pr) * N + int'(pc);
    probe_cell = 2'b00;
    for (int i = 0; i < CELLS; i++) begin
      if (on_board && (i == pidx)) probe_cell = board_q[2*i +: 2];
    end
    probe_match = on_board && (probe_cell == turn_q);
  end

  // Next-state: move validation in IDLE, one probe per cycle in SCAN, status update in RESULT.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    off_d    = off_q;
    dir_d    = dir_q;
    side_d   = side_q;
    win_d    = win_q;
    lr_d     = lr_q;
    lc_d     = lc_q;
    code_d   = code_q;
    status_d = status_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rv_d     = 1'b0;
    side_end = 1'b0;
    in_range = (int'(bus.move_row) < N) && (int'(bus.move_col) < N);
    midx     = int'(bus.move_row) * N + int'(bus.move_col);
    occupied = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (in_range && (i == midx)) occupied = |board_q[2*i +: 2];
    end

    case (state_q)
      IDLE: begin
        if (bus.move_valid) begin
          if (!in_range) begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end else if (occupied) begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end else if (bus.move_player != turn_q) begin
            err_d  = 1'b1;
            code_d = 2'b11;
          end else begin
            for (int i = 0; i < CELLS; i++) begin
              if (i == midx) board_d[2*i +: 2] = bus.move_player;
            end
            ack_d   = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            lr_d    = bus.move_row;
            lc_d    = bus.move_col;
            dir_d   = 2'd0;
            side_d  = 1'b0;
            off_d   = OW'(1);
            run_d   = RW'(1);
            win_d   = 1'b0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (probe_match) begin
          run_d = run_q + RW'(1);
          if (int'(run_q) + 1 >= K) begin
            win_d   = 1'b1;
            state_d = RESULT;
          end else if (int'(off_q) == K - 1) begin
            side_end = 1'b1;
          end else begin
            off_d = off_q + OW'(1);
          end
        end else begin
          side_end = 1'b1;
        end
        if (side_end) begin
          off_d = OW'(1);
          if (!side_q) begin
            side_d = 1'b1;
          end else if (dir_q == 2'd3) begin
            state_d = RESULT;
          end else begin
            dir_d  = dir_q + 2'd1;
            side_d = 1'b0;
            run_d  = RW'(1);
          end
        end
      end
      RESULT: begin
        rv_d = 1'b1;
        if (win_q) begin
          status_d = turn_q;
          state_d  = OVER;
        end else if (int'(cnt_q) == CELLS) begin
          status_d = 2'b11;
          state_d  = OVER;
        end else begin
          status_d = 2'b00;
          turn_d   = (turn_q == 2'b01) ? 2'b10 : 2'b01;
          state_d  = IDLE;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset and new_game both clear the whole game, aborting any scan.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state_q  <= IDLE;
      board_q  <= '0;
      turn_q   <= 2'b01;
      cnt_q    <= '0;
      run_q    <= '0;
      off_q    <= '0;
      dir_q    <= '0;
      side_q   <= 1'b0;
      win_q    <= 1'b0;
      lr_q     <= '0;
      lc_q     <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
      code_q   <= 2'b00;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      off_q    <= off_d;
      dir_q    <= dir_d;
      side_q   <= side_d;
      win_q    <= win_d;
      lr_q     <= lr_d;
      lc_q     <= lc_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rv_q     <= rv_d;
      code_q   <= code_d;
      status_q <= status_d;
    end
  end

  assign bus.move_ready   = (state_q == IDLE);
  assign bus.move_ack     = ack_q;
  assign bus.move_err     = err_q;
  assign bus.err_code     = code_q;
  assign bus.status       = status_q;
  assign bus.result_valid = rv_q;
  assign bus.board_flat   = board_q;
endmodule

// File: tb/tb_ttt_judge.sv
// Directed bench for ttt_judge: a 3x3/K=3 instance and a 5x5/K=4 instance share one clock.
// Table of moves with expected ack/err/code/status/probe count, then hand-written reset and game-over sequences.
module tb_ttt_judge;
  logic clk = 1'b0;
  logic rst3, ng3, rst5, ng5;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ttt_judge_if #(.N(3)) bus3 ();
  ttt_judge_if #(.N(5)) bus5 ();

  ttt_judge #(.N(3), .K(3)) dut3 (.clk(clk), .reset(rst3), .new_game(ng3), .bus(bus3.slave));
  ttt_judge #(.N(5), .K(4)) dut5 (.clk(clk), .reset(rst5), .new_game(ng5), .bus(bus5.slave));

  typedef struct {
    int          sel;
    bit          clr;
    int          r, c, p;
    bit          exp_err;
    int          exp_code;
    int          exp_st;
    int          exp_probes;
    bit          chk_board;
    logic [17:0] exp_board;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input bit clr, input int r, input int c, input int p,
                              input bit e, input int code, input int st, input int probes,
                              input bit cb, input logic [17:0] b);
    vec_t v;
    v.sel = sel; v.clr = clr; v.r = r; v.c = c; v.p = p;
    v.exp_err = e; v.exp_code = code; v.exp_st = st; v.exp_probes = probes;
    v.chk_board = cb; v.exp_board = b;
    return v;
  endfunction

  task automatic clear(input int sel);
    @(negedge clk);
    if (sel == 3) ng3 = 1'b1; else ng5 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
    ng5 = 1'b0;
  endtask

  task automatic do_move(input int sel, input int r, input int c, input int p,
                         output bit ack, output bit err, output bit rv,
                         output logic [1:0] code, output logic [1:0] st, output int probes);
    int n;
    bit cur_rv;
    @(negedge clk);
    if (sel == 3) begin
      bus3.move_valid = 1'b1; bus3.move_row = 2'(r); bus3.move_col = 2'(c); bus3.move_player = 2'(p);
    end else begin
      bus5.move_valid = 1'b1; bus5.move_row = 3'(r); bus5.move_col = 3'(c); bus5.move_player = 2'(p);
    end
    @(negedge clk);
    bus3.move_valid = 1'b0;
    bus5.move_valid = 1'b0;
    ack    = (sel == 3) ? bus3.move_ack : bus5.move_ack;
    err    = (sel == 3) ? bus3.move_err : bus5.move_err;
    code   = (sel == 3) ? bus3.err_code : bus5.err_code;
    rv     = 1'b0;
    st     = 2'b00;
    probes = -1;
    if (ack) begin
      n = 0;
      cur_rv = 1'b0;
      while (!cur_rv && n < 200) begin
        @(negedge clk);
        n++;
        cur_rv = (sel == 3) ? bus3.result_valid : bus5.result_valid;
      end
      if (cur_rv) begin
        rv     = 1'b1;
        st     = (sel == 3) ? bus3.status : bus5.status;
        probes = n - 1;
      end
    end
  endtask

  initial begin
    bit          ack, err, rv, seen;
    logic [1:0]  code, st;
    int          probes;

    // game 1: P1 wins top row
    vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 0, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 1, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 0, 2, 1, 0, 0, 1,  3, 0, '0));
    // errors and their priority; board keeps only P1 at (0,0)
    vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 1, 1, 1, 1, 3, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 0, 0, 2, 1, 2, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 3, 0, 2, 1, 1, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 0, 0, 1, 1, 2, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 3, 3, 1, 1, 1, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 0, 3, 2, 1, 1, 0, -1, 1, 18'h1));
    vecs.push_back(mk(3, 0, 1, 1, 2, 0, 0, 0, -1, 1, 18'h201));
    // full board, no line -> tie
    vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 0, 1, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 0, 2, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 1, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 0, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 2, 0, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 2, 1, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 2, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 2, 2, 1, 0, 0, 3, -1, 0, '0));
    // full board, ninth move closes the main diagonal -> win beats tie
    vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 0, 1, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 0, 2, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 0, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 1, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 1, 2, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 2, 1, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 2, 0, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(3, 0, 2, 2, 1, 0, 0, 1,  8, 0, '0));
    // 5x5 K=4: P2 closes anti-diagonal at (2,2); 10 probes
    vecs.push_back(mk(5, 1, 0, 0, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 0, 4, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 0, 1, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 1, 3, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 1, 0, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 3, 1, 2, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 4, 4, 1, 0, 0, 0, -1, 0, '0));
    vecs.push_back(mk(5, 0, 2, 2, 2, 0, 0, 2, 10, 0, '0));

    bus3.move_valid = 1'b0; bus3.move_row = '0; bus3.move_col = '0; bus3.move_player = '0;
    bus5.move_valid = 1'b0; bus5.move_row = '0; bus5.move_col = '0; bus5.move_player = '0;
    rst3 = 1'b1; rst5 = 1'b1; ng3 = 1'b0; ng5 = 1'b0;
    repeat (3) @(negedge clk);
    rst3 = 1'b0; rst5 = 1'b0;
    @(negedge clk);

    chk("rst_ready3",  int'(bus3.move_ready), 1);
    chk("rst_status3", int'(bus3.status), 0);
    chk("rst_board3",  int'(bus3.board_flat), 0);
    chk("rst_code3",   int'(bus3.err_code), 0);
    chk("rst_pulses3", int'({bus3.move_ack, bus3.move_err, bus3.result_valid}), 0);
    chk("rst_ready5",  int'(bus5.move_ready), 1);
    chk("rst_board5",  (bus5.board_flat == '0) ? 1 : 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].clr) clear(vecs[i].sel);
      do_move(vecs[i].sel, vecs[i].r, vecs[i].c, vecs[i].p, ack, err, rv, code, st, probes);
      chk($sformatf("v%0d_ack", i), int'(ack), vecs[i].exp_err ? 0 : 1);
      chk($sformatf("v%0d_err", i), int'(err), vecs[i].exp_err ? 1 : 0);
      if (vecs[i].exp_err) begin
        chk($sformatf("v%0d_code", i), int'(code), vecs[i].exp_code);
      end else begin
        chk($sformatf("v%0d_rv", i), int'(rv), 1);
        chk($sformatf("v%0d_status", i), int'(st), vecs[i].exp_st);
        if (vecs[i].exp_probes >= 0)
          chk($sformatf("v%0d_probes", i), probes, vecs[i].exp_probes);
      end
      if (vecs[i].chk_board)
        chk($sformatf("v%0d_board", i), int'(bus3.board_flat), int'(vecs[i].exp_board));
    end

    // 5x5 instance is now in OVER: moves ignored without errors
    chk("over_ready", int'(bus5.move_ready), 0);
    @(negedge clk);
    bus5.move_valid = 1'b1; bus5.move_row = 3'd4; bus5.move_col = 3'd0; bus5.move_player = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("over_ack%0d", k), int'(bus5.move_ack), 0);
      chk($sformatf("over_err%0d", k), int'(bus5.move_err), 0);
    end
    bus5.move_valid = 1'b0;
    chk("over_status_held", int'(bus5.status), 2);

    // new_game from OVER returns to IDLE with P1 to move
    clear(5);
    chk("ng_ready",  int'(bus5.move_ready), 1);
    chk("ng_status", int'(bus5.status), 0);
    chk("ng_board",  (bus5.board_flat == '0) ? 1 : 0, 1);
    do_move(5, 2, 2, 1, ack, err, rv, code, st, probes);
    chk("ng_p1_ack", int'(ack), 1);
    chk("ng_p1_status", int'(st), 0);

    // reset in the middle of a scan aborts it
    clear(3);
    @(negedge clk);
    bus3.move_valid = 1'b1; bus3.move_row = 2'd1; bus3.move_col = 2'd1; bus3.move_player = 2'b01;
    @(negedge clk);
    bus3.move_valid = 1'b0;
    chk("scan_ack",   int'(bus3.move_ack), 1);
    chk("scan_board", int'(bus3.board_flat), 32'h100);
    chk("scan_busy",  int'(bus3.move_ready), 0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("abort_status", int'(bus3.status), 0);
    chk("abort_board",  int'(bus3.board_flat), 0);
    chk("abort_ready",  int'(bus3.move_ready), 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus3.result_valid) seen = 1'b1;
    end
    chk("abort_no_rv", int'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
